// File: rtl/pipe_pkg.sv
// Shared constants and stage select type for the pipeline register chain.
// Stage indices and the SPARC nop used to fill empty stages.
package pipe_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0100_0000;

    localparam int IF_ID  = 0;
    localparam int ID_EX  = 1;
    localparam int EX_MEM = 2;
    localparam int MEM_WB = 3;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        HOLD   = 2'd1,
        BUBBLE = 2'd2,
        KILL   = 2'd3
    } stage_ctrl_t;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register: WIDTH data bits plus a valid flag.
// Invalid contents always read back as NOP_VALUE.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] NOP_VALUE = NOP_INSTR
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             reset,
    input  stage_ctrl_t      sel,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q       <= NOP_VALUE;
            q_valid <= 1'b0;
        end else if (reset) begin
            q       <= NOP_VALUE;
            q_valid <= 1'b0;
        end else begin
            unique case (sel)
                LOAD: begin
                    // Invalid input never leaves stale data behind
                    q       <= d_valid ? d : NOP_VALUE;
                    q_valid <= d_valid;
                end
                HOLD: begin
                    q       <= q;
                    q_valid <= q_valid;
                end
                BUBBLE, KILL: begin
                    q       <= NOP_VALUE;
                    q_valid <= 1'b0;
                end
                default: begin
                    q       <= NOP_VALUE;
                    q_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage pipeline register chain with hold, flush and bubble insertion.
// Optional PIPE_PERF_EN adds saturating stall/bubble counters.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] NOP_VALUE = NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DEPTH-1:0]       hold,
    input  logic [DEPTH-1:0]       flush,
    output logic [DEPTH*WIDTH-1:0] stage_data,
    output logic [DEPTH-1:0]       stage_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid
`ifdef PIPE_PERF_EN
    ,
    output logic [15:0]            stall_cycles,
    output logic [15:0]            bubble_count
`endif
);

    logic [DEPTH-1:0] eh;
    logic [WIDTH-1:0] sd [DEPTH];
    logic [DEPTH-1:0] sv;
    stage_ctrl_t      sel [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        // A stall anywhere downstream freezes this stage too
        assign eh[k] = |hold[DEPTH-1:k];

        if (k == 0) begin : g_head
            always_comb begin
                sel[k] = LOAD;
                unique case (1'b1)
                    flush[k]:             sel[k] = KILL;
                    (!flush[k] && eh[k]): sel[k] = HOLD;
                    default:              sel[k] = LOAD;
                endcase
            end

            pipe_stage #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_stage (
                .clk     (clk),
                .clr     (clr),
                .reset   (reset),
                .sel     (sel[k]),
                .d       (in_data),
                .d_valid (in_valid),
                .q       (sd[k]),
                .q_valid (sv[k])
            );
        end else begin : g_body
            always_comb begin
                sel[k] = LOAD;
                unique case (1'b1)
                    flush[k]:                           sel[k] = KILL;
                    (!flush[k] && eh[k]):               sel[k] = HOLD;
                    (!flush[k] && !eh[k] && eh[k-1]):   sel[k] = BUBBLE;
                    default:                            sel[k] = LOAD;
                endcase
            end

            pipe_stage #(.WIDTH(WIDTH), .NOP_VALUE(NOP_VALUE)) u_stage (
                .clk     (clk),
                .clr     (clr),
                .reset   (reset),
                .sel     (sel[k]),
                .d       (sd[k-1]),
                .d_valid (sv[k-1]),
                .q       (sd[k]),
                .q_valid (sv[k])
            );
        end

        assign stage_data[k*WIDTH +: WIDTH] = sd[k];
    end

    assign stage_valid = sv;
    assign out_data    = sd[DEPTH-1];
    assign out_valid   = sv[DEPTH-1];
    assign in_ready    = ~eh[0];

`ifdef PIPE_PERF_EN
    logic [DEPTH-1:0] bub;
    logic             bubble_any;

    for (genvar k = 0; k < DEPTH; k++) begin : g_bub
        assign bub[k] = (sel[k] == BUBBLE);
    end

    assign bubble_any = |bub;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            stall_cycles <= '0;
            bubble_count <= '0;
        end else if (reset) begin
            stall_cycles <= '0;
            bubble_count <= '0;
        end else begin
            if (eh[0] && in_valid && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
            if (bubble_any && bubble_count != 16'hFFFF)
                bubble_count <= bubble_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed scoreboard bench for pipe_stage_chain (WIDTH=32, DEPTH=4).
// Define PIPE_PERF_EN to also exercise the performance counters.
module tb_pipe_stage_chain;

    localparam int          W   = 32;
    localparam int          D   = 4;
    localparam logic [31:0] NOP = 32'h0100_0000;

    logic           clk = 1'b0;
    logic           clr;
    logic           reset;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_ready;
    logic [D-1:0]   hold;
    logic [D-1:0]   flush;
    logic [D*W-1:0] stage_data;
    logic [D-1:0]   stage_valid;
    logic [W-1:0]   out_data;
    logic           out_valid;
`ifdef PIPE_PERF_EN
    logic [15:0]    stall_cycles;
    logic [15:0]    bubble_count;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q [$];

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .NOP_VALUE(NOP)) dut (
        .clk          (clk),
        .clr          (clr),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .hold         (hold),
        .flush        (flush),
        .stage_data   (stage_data),
        .stage_valid  (stage_valid),
        .out_data     (out_data),
        .out_valid    (out_valid)
`ifdef PIPE_PERF_EN
        ,
        .stall_cycles (stall_cycles),
        .bubble_count (bubble_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>",
                   tag, out_data);
        end else begin
            e = exp_q.pop_front();
            chk(tag, {96'd0, out_data}, {96'd0, e});
        end
    endtask

    function automatic logic [127:0] pack(input logic [31:0] a0,
        input logic [31:0] a1, input logic [31:0] a2, input logic [31:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic fill_abcd;
        for (int i = 0; i < 4; i++) begin
            in_data  = 32'hA + 32'(i);
            in_valid = 1'b1;
            exp_q.push_back(in_data);
            tick();
        end
        in_valid = 1'b0;
        sb_check("fill_out_A");
    endtask

    initial begin
        clr      = 1'b0;
        reset    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        hold     = '0;
        flush    = '0;
        #12;
        chk("rst_valid", stage_valid, 4'b0000);
        chk("rst_data", stage_data, pack(NOP, NOP, NOP, NOP));
        chk("rst_ready", in_ready, 1'b1);
        clr = 1'b1;

        // Streaming latency: A appears after the 4th edge
        for (int e = 1; e <= 8; e++) begin
            if (e <= 4) begin
                in_data  = 32'hA + 32'(e - 1);
                in_valid = 1'b1;
                exp_q.push_back(in_data);
            end else begin
                in_data  = 32'hDEAD;
                in_valid = 1'b0;
            end
            tick();
            if (e >= 4 && e <= 7) begin
                chk($sformatf("lat_valid_e%0d", e), out_valid, 1'b1);
                sb_check($sformatf("stream_out_e%0d", e));
            end else begin
                chk($sformatf("lat_idle_e%0d", e), out_valid, 1'b0);
            end
        end
        chk("drain_data", out_data, NOP);
        chk("sb_drained", exp_q.size(), 0);

        // Hold on stage 1 for one cycle
        fill_abcd();
        chk("fill_data", stage_data, pack(32'hD, 32'hC, 32'hB, 32'hA));
        hold = 4'b0010;
        #1;
        chk("hold1_ready", in_ready, 1'b0);
        tick();
        hold = '0;
        chk("hold1_valid", stage_valid, 4'b1011);
        chk("hold1_data", stage_data, pack(32'hD, 32'hC, NOP, 32'hB));
        sb_check("hold1_out_B");

        // Asynchronous clear mid-run
        #2;
        clr = 1'b0;
        #1;
        chk("aclr_valid", stage_valid, 4'b0000);
        chk("aclr_data", stage_data, pack(NOP, NOP, NOP, NOP));
        #1;
        clr = 1'b1;
        exp_q.delete();

        // Flush beats hold on stage 0; downstream advances
        fill_abcd();
        flush    = 4'b0011;
        hold     = 4'b0001;
        in_valid = 1'b1;
        in_data  = 32'hE;
        #1;
        chk("flush_ready", in_ready, 1'b0);
        exp_q.push_back(32'hB);
        tick();
        flush    = '0;
        hold     = '0;
        in_valid = 1'b0;
        chk("flush_valid", stage_valid, 4'b1100);
        chk("flush_data", stage_data, pack(NOP, NOP, 32'hC, 32'hB));
        sb_check("flush_out_B");

        // Invalid input never lands as stale data
        in_data = 32'h1234;
        tick();
        chk("inval_data", stage_data, pack(NOP, NOP, NOP, 32'hC));
        chk("inval_valid", stage_valid, 4'b1000);

        // hold on last stage freezes the whole chain
        hold     = 4'b1000;
        in_valid = 1'b1;
        in_data  = 32'hF;
        tick();
        chk("freeze_data", stage_data, pack(NOP, NOP, NOP, 32'hC));
        chk("freeze_valid", stage_valid, 4'b1000);

        // Synchronous reset beats hold
        hold  = 4'b1111;
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        hold     = '0;
        in_valid = 1'b0;
        chk("sreset_valid", stage_valid, 4'b0000);
        chk("sreset_data", stage_data, pack(NOP, NOP, NOP, NOP));

`ifdef PIPE_PERF_EN
        chk("perf_stall_zero", stall_cycles, 16'd0);
        chk("perf_bub_zero", bubble_count, 16'd0);
        hold     = 4'b1000;
        in_valid = 1'b1;
        in_data  = 32'h77;
        for (int i = 0; i < 70000; i++) @(posedge clk);
        #1;
        chk("perf_stall_sat", stall_cycles, 16'hFFFF);
        chk("perf_bub_none", bubble_count, 16'd0);
        hold = 4'b0001;
        for (int i = 0; i < 3; i++) tick();
        chk("perf_bub_3", bubble_count, 16'd3);
        chk("perf_stall_hold", stall_cycles, 16'hFFFF);
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        hold     = '0;
        in_valid = 1'b0;
        chk("perf_stall_rst", stall_cycles, 16'd0);
        chk("perf_bub_rst", bubble_count, 16'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
